// File: rtl/secret_file_writer.sv
// ============================================================================
// secret_file_writer
// ----------------------------------------------------------------------------
// Captures a framed character file into a small buffer and reads it back.
// A file is STX (7'h02), up to WORD_COUNT data characters, then ETX (7'h03).
// STX restarts capture from any state. When the file completes, the buffer is
// frozen ("locked") and can be read one entry per cycle through rd_idx/rd_char.
//
// Optional feature macro: SECRET_FILE_CHECKSUM_EN
//   When defined, each file carries a trailing checksum character after ETX.
//   This character must equal the XOR of all stored data characters. A mismatch,
//   or an overflow, ends in the ERROR state with err=1. When the macro is not
//   defined, ETX locks the file directly and err is tied to 0.
//
// Parameters
//   WORD_COUNT : number of 7-bit buffer entries (power of two, 2..64)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   din       in   [6:0]   incoming character code
//   din_valid in   qualifies din for exactly the cycle it is high
//   rd_idx    in   [AW-1:0] buffer entry selected for readout
//   rd_char   out  [6:0]   registered readout, one cycle after rd_idx;
//                          7'h00 unless locked and rd_idx < count
//   count     out  [AW:0]  number of stored characters (saturates)
//   locked    out  high exactly while the state is LOCKED
//   ovf       out  data arrived with the buffer already full
//   err       out  checksum / overflow error (checksum build only)
// ============================================================================
module secret_file_writer #(
    parameter int WORD_COUNT = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [6:0]                    din,
    input  logic                          din_valid,
    input  logic [$clog2(WORD_COUNT)-1:0] rd_idx,
    output logic [6:0]                    rd_char,
    output logic [$clog2(WORD_COUNT):0]   count,
    output logic                          locked,
    output logic                          ovf,
    output logic                          err
);

    localparam int AW     = $clog2(WORD_COUNT);
    localparam int DATA_W = 7;

    localparam logic [DATA_W-1:0] STX  = 7'h02;
    localparam logic [DATA_W-1:0] ETX  = 7'h03;
    localparam logic [AW:0]       FULL = (AW+1)'(WORD_COUNT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RECV   = 3'd1,
`ifdef SECRET_FILE_CHECKSUM_EN
        S_CHK    = 3'd2,
`endif
        S_LOCKED = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    // Count never wraps: it sticks at FULL once the buffer is full.
    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        if (v == FULL) begin
            return v;
        end
        return v + (AW+1)'(1);
    endfunction

    // Readout is only meaningful for entries that hold file data.
    function automatic logic in_file(input logic [AW-1:0] idx, input logic [AW:0] n);
        return ({1'b0, idx} < n);
    endfunction

    state_t              state, state_n;
    logic [AW:0]         count_n;
    logic                ovf_n;
    logic                wr_en;
    logic [DATA_W-1:0]   mem [WORD_COUNT];

`ifdef SECRET_FILE_CHECKSUM_EN
    logic [DATA_W-1:0]   csum, csum_n;
    logic                err_q, err_n;
`endif

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_n = state;
        count_n = count;
        ovf_n   = ovf;
        wr_en   = 1'b0;
`ifdef SECRET_FILE_CHECKSUM_EN
        csum_n  = csum;
        err_n   = err_q;
`endif
        if (din_valid) begin
            if (din == STX) begin
                // STX wins in every state and starts a clean file.
                state_n = S_RECV;
                count_n = '0;
                ovf_n   = 1'b0;
`ifdef SECRET_FILE_CHECKSUM_EN
                csum_n  = '0;
                err_n   = 1'b0;
`endif
            end else begin
                case (state)
                    S_RECV: begin
                        if (din == ETX) begin
`ifdef SECRET_FILE_CHECKSUM_EN
                            state_n = S_CHK;
`else
                            state_n = S_LOCKED;
`endif
                        end else if (count != FULL) begin
                            wr_en   = 1'b1;
                            count_n = sat_inc(count);
`ifdef SECRET_FILE_CHECKSUM_EN
                            csum_n  = csum ^ din;
`endif
                        end else begin
                            // Buffer full: the character is dropped.
                            ovf_n = 1'b1;
`ifdef SECRET_FILE_CHECKSUM_EN
                            state_n = S_ERROR;
                            err_n   = 1'b1;
`else
                            state_n = S_LOCKED;
`endif
                        end
                    end
`ifdef SECRET_FILE_CHECKSUM_EN
                    S_CHK: begin
                        // Any non-STX character here is the checksum, ETX included.
                        if (din == csum) begin
                            state_n = S_LOCKED;
                        end else begin
                            state_n = S_ERROR;
                            err_n   = 1'b1;
                        end
                    end
`endif
                    default: begin
                        // IDLE, LOCKED, ERROR ignore everything but STX.
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            ovf   <= ovf_n;
        end
    end

`ifdef SECRET_FILE_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else begin
            csum  <= csum_n;
            err_q <= err_n;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign locked = (state == S_LOCKED);

    // ------------------------------------------------------------------------
    // Buffer storage (no reset: contents are masked until a file locks)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[AW-1:0]] <= din;
        end
    end

    // ------------------------------------------------------------------------
    // Registered readout; a same-cycle write to the same entry is not visible
    // until the following read (old value returned).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_char <= '0;
        end else if (locked && in_file(rd_idx, count)) begin
            rd_char <= mem[rd_idx];
        end else begin
            rd_char <= '0;
        end
    end

endmodule

// File: tb/tb_secret_file_writer.sv
// ============================================================================
// tb_secret_file_writer
// Directed bench for secret_file_writer. A character-level model of the file
// protocol runs alongside the DUT and is compared against it every cycle. The
// directed sequences also check hand-computed literal values.
// ============================================================================
module tb_secret_file_writer;

    localparam int WC = 32;
    localparam int AW = $clog2(WC);

`ifdef SECRET_FILE_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam logic [6:0] STX = 7'h02;
    localparam logic [6:0] ETX = 7'h03;

    // Model states (abstract, independent of any RTL encoding).
    localparam int M_IDLE = 0;
    localparam int M_RECV = 1;
    localparam int M_CHK  = 2;
    localparam int M_LOCK = 3;
    localparam int M_ERR  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    din = 7'h00;
    logic          din_valid = 1'b0;
    logic [AW-1:0] rd_idx = '0;
    logic [6:0]    rd_char;
    logic [AW:0]   count;
    logic          locked;
    logic          ovf;
    logic          err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    int         m_state = M_IDLE;
    int         m_count = 0;
    bit         m_ovf   = 1'b0;
    bit         m_err   = 1'b0;
    logic [6:0] m_sum   = 7'h00;
    logic [6:0] m_rd    = 7'h00;
    logic [6:0] m_mem [WC];

    secret_file_writer #(.WORD_COUNT(WC)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .rd_idx    (rd_idx),
        .rd_char   (rd_char),
        .count     (count),
        .locked    (locked),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: advances one character per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_state = M_IDLE;
                m_count = 0;
                m_ovf   = 1'b0;
                m_err   = 1'b0;
                m_sum   = 7'h00;
                m_rd    = 7'h00;
            end else begin
                m_rd = (m_state == M_LOCK && int'(rd_idx) < m_count) ? m_mem[int'(rd_idx)] : 7'h00;
                if (din_valid) begin
                    if (din == STX) begin
                        m_state = M_RECV;
                        m_count = 0;
                        m_ovf   = 1'b0;
                        m_err   = 1'b0;
                        m_sum   = 7'h00;
                    end else if (m_state == M_RECV) begin
                        if (din == ETX) begin
                            m_state = CHK_EN ? M_CHK : M_LOCK;
                        end else if (m_count < WC) begin
                            m_mem[m_count] = din;
                            m_count++;
                            m_sum = m_sum ^ din;
                        end else begin
                            m_ovf = 1'b1;
                            if (CHK_EN) begin
                                m_state = M_ERR;
                                m_err   = 1'b1;
                            end else begin
                                m_state = M_LOCK;
                            end
                        end
                    end else if (m_state == M_CHK) begin
                        if (din == m_sum) begin
                            m_state = M_LOCK;
                        end else begin
                            m_state = M_ERR;
                            m_err   = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("cyc_count",  32'(count),   32'(m_count));
            check("cyc_locked", 32'(locked),  32'(m_state == M_LOCK));
            check("cyc_ovf",    32'(ovf),     32'(m_ovf));
            check("cyc_err",    32'(err),     32'(m_err));
            check("cyc_rdchar", 32'(rd_char), 32'(m_rd));
        end
    end

    // Drive a valid character for the next edge.
    task automatic send(input logic [6:0] c);
        @(posedge clk);
        #2;
        din       = c;
        din_valid = 1'b1;
    endtask

    // Advance one edge with din_valid low; returns at edge+2.
    task automatic cyc();
        @(posedge clk);
        #2;
        din_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) cyc();
        #1;
        check("rst_count",  32'(count),   32'd0);
        check("rst_locked", 32'(locked),  32'd0);
        check("rst_ovf",    32'(ovf),     32'd0);
        check("rst_err",    32'(err),     32'd0);
        check("rst_rdchar", 32'(rd_char), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Basic file "HI"
        send(STX); send(7'h48); send(7'h49); send(ETX);
        if (CHK_EN) send(7'h01);
        cyc();
        #1;
        check("basic_count",  32'(count),  32'd2);
        check("basic_locked", 32'(locked), 32'd1);
        rd_idx = 5'd1;
        cyc();
        #1;
        check("basic_rd1", 32'(rd_char), 32'h49);
        rd_idx = 5'd2;
        cyc();
        #1;
        check("basic_rd2", 32'(rd_char), 32'h00);

        // STX held with din_valid low changes nothing
        @(posedge clk);
        #2;
        din       = STX;
        din_valid = 1'b0;
        repeat (5) cyc();
        #1;
        check("hold_locked", 32'(locked), 32'd1);
        check("hold_count",  32'(count),  32'd2);

        // Checksum good, then bad
        send(STX); send(7'h48); send(7'h49); send(ETX); send(7'h01);
        cyc();
        #1;
        check("csum_ok_locked", 32'(locked), 32'd1);
        check("csum_ok_err",    32'(err),    32'd0);
        send(STX); send(7'h48); send(7'h49); send(ETX); send(7'h05);
        cyc();
        #1;
        check("csum_bad_err",    32'(err),    CHK_EN ? 32'd1 : 32'd0);
        check("csum_bad_locked", 32'(locked), CHK_EN ? 32'd0 : 32'd1);

        // Overflow: 33 data characters 0x10..0x30
        send(STX);
        for (int i = 0; i < 33; i++) send(7'(8'h10 + i));
        cyc();
        #1;
        check("ovf_count",  32'(count),  32'd32);
        check("ovf_flag",   32'(ovf),    32'd1);
        check("ovf_locked", 32'(locked), CHK_EN ? 32'd0 : 32'd1);
        check("ovf_err",    32'(err),    CHK_EN ? 32'd1 : 32'd0);
        rd_idx = 5'd31;
        cyc();
        #1;
        check("ovf_rd31", 32'(rd_char), CHK_EN ? 32'h00 : 32'h2F);

        // Restart mid-file
        send(STX); send(7'h41); send(STX); send(7'h42); send(ETX);
        if (CHK_EN) send(7'h42);
        cyc();
        #1;
        check("restart_count",  32'(count),  32'd1);
        check("restart_locked", 32'(locked), 32'd1);
        rd_idx = 5'd0;
        cyc();
        #1;
        check("restart_rd0", 32'(rd_char), 32'h42);
        send(STX);
        cyc();
        #1;
        check("restart_unlock", 32'(locked), 32'd0);

        // Reset mid-file
        send(STX); send(7'h41);
        @(posedge clk);
        #2;
        din_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        send(7'h42); send(ETX);
        cyc();
        #1;
        check("midrst_count",  32'(count),  32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_ovf",    32'(ovf),    32'd0);

        // Empty file
        send(STX); send(ETX);
        if (CHK_EN) send(7'h00);
        cyc();
        #1;
        check("empty_locked", 32'(locked), 32'd1);
        check("empty_count",  32'(count),  32'd0);
        rd_idx = 5'd0;
        cyc();
        #1;
        check("empty_rd0", 32'(rd_char), 32'h00);

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
